// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit A + B + cin, one CHUNK-bit slice per stage,
// carry registered between stages, elastic valid/ready handshake on both sides.
module pipelined_rca_adder #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned CHUNK = WIDTH / STAGES;

   if ((WIDTH < 1) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("pipelined_rca_adder: WIDTH must be a positive multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   // Per-stage token registers. Operands are stored pre-shifted so every stage adds the
   // low CHUNK bits of what it receives; the sum accumulates in place, slice k at stage k.
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] c_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];

   // Stage inputs (stage 0 fed from the ports, stage k from register k-1) and results.
   logic [STAGES-1:0] op_v;
   logic [STAGES-1:0] op_c;
   logic [WIDTH-1:0]  op_a [STAGES];
   logic [WIDTH-1:0]  op_b [STAGES];
   logic [WIDTH-1:0]  op_s [STAGES];
   logic [CHUNK:0]    slice_sum [STAGES];
   logic [WIDTH-1:0]  ns [STAGES];
   logic [STAGES-1:0] nc;
   logic [STAGES-1:0] adv;

   // Route each stage's operands and compute its CHUNK-bit slice with carry.
   always_comb begin
      op_v[0] = in_valid;
      op_c[0] = cin;
      op_a[0] = A;
      op_b[0] = B;
      op_s[0] = '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         op_v[k] = v_q[k-1];
         op_c[k] = c_q[k-1];
         op_a[k] = a_q[k-1];
         op_b[k] = b_q[k-1];
         op_s[k] = s_q[k-1];
      end
      nc = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         slice_sum[k] = {1'b0, op_a[k][CHUNK-1:0]} + {1'b0, op_b[k][CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, op_c[k]};
         ns[k] = op_s[k];
         ns[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
         nc[k] = slice_sum[k][CHUNK];
      end
   end

   // A stage advances unless it and every stage after it are full with the output stalled;
   // expressed as a tail-full scan so no signal depends on itself.
   always_comb begin
      logic tail_full;
      tail_full = 1'b1;
      adv       = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         tail_full             = tail_full & v_q[STAGES-1-i];
         adv[STAGES-1-i]       = out_ready | ~tail_full;
      end
   end

   assign in_ready  = ~rst & adv[0];
   assign S         = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign out_valid = v_q[STAGES-1];

   // Pipeline registers: clear everything on reset, otherwise load each advancing stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         c_q <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               v_q[k] <= op_v[k];
               c_q[k] <= nc[k];
               a_q[k] <= op_a[k] >> CHUNK;
               b_q[k] <= op_b[k] >> CHUNK;
               s_q[k] <= ns[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder: table-driven streams, handshake corner
// sequences on an 8/4 instance, and randomised sweeps on 1/1, 16/8 and 8/1 instances.
module tb_pipelined_rca_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   // Main 8-bit / 4-stage instance
   logic       rst, iv, ir, ordy, cin, co, ov;
   logic [7:0] a, b, s;

   pipelined_rca_adder #(.WIDTH(8), .STAGES(4)) dut (
      .clk(clk), .rst(rst), .A(a), .B(b), .cin(cin), .in_valid(iv), .in_ready(ir),
      .S(s), .cout(co), .out_valid(ov), .out_ready(ordy)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t       tv [8];
   logic [8:0] exp_q [$];
   int         acc_q [$];
   bit         check_lat = 1'b0;
   int         n_out = 0;
   logic       sweep_go = 1'b0;
   logic [2:0] sdone = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle at the negedge, score any output transfer, record any input transfer.
   task automatic step(input logic v, input logic [7:0] a_, input logic [7:0] b_, input logic c_,
                       input logic [8:0] e, input logic ordy_, output logic acc);
      logic [8:0] e0;
      int         t0;
      iv = v; a = a_; b = b_; cin = c_; ordy = ordy_;
      #1;
      acc = iv && ir;
      if (ov && ordy) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: got S=%0h cout=%0b with nothing in flight", s, co);
         end else begin
            e0 = exp_q.pop_front();
            t0 = acc_q.pop_front();
            check("sum", {23'd0, co, s}, {23'd0, e0});
            if (check_lat) check("latency", cyc - t0, 4);
         end
      end
      if (acc) begin
         exp_q.push_back(e);
         acc_q.push_back(cyc);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      logic acc;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) step(1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
      check({tag, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
   endtask

   task automatic stream(input int first, input int last);
      logic acc;
      for (int i = first; i <= last; i++) begin
         step(1'b1, tv[i].a, tv[i].b, tv[i].c, {tv[i].co, tv[i].s}, 1'b1, acc);
         check("accept_stream", acc, 1);
      end
   endtask

   initial begin
      logic       acc;
      logic [7:0] ba [8], bb [8];
      logic       bc [8];
      logic [8:0] held;
      int         i, out0;

      tv[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tv[1] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
      tv[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      tv[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      tv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      tv[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      tv[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      tv[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

      rst = 1'b1; iv = 1'b1; ordy = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1;

      // Reset holds: offers ignored, outputs cleared
      @(negedge clk);
      repeat (5) begin
         #1;
         check("rst_in_ready", ir, 0);
         check("rst_out_valid", ov, 0);
         check("rst_S", s, 0);
         check("rst_cout", co, 0);
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b0;
      repeat (6) step(1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
      check("no_output_after_reset", n_out, 0);

      // Back-to-back stream with latency check, then carry-ripple and extra vectors
      check_lat = 1'b1;
      stream(0, 2);
      drain("stream");
      stream(3, 7);
      drain("ripple");
      check_lat = 1'b0;

      // Backpressure: capacity is STAGES tokens, outputs held while stalled
      for (int k = 0; k < 8; k++) begin
         ba[k] = 8'($urandom); bb[k] = 8'($urandom); bc[k] = 1'($urandom);
      end
      out0 = n_out;
      i = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, ba[i], bb[i], bc[i], {1'b0, ba[i]} + {1'b0, bb[i]} + {8'd0, bc[i]}, 1'b0, acc);
         if (acc) i++;
      end
      check("bp_accepted", i, 4);
      ordy = 1'b0; iv = 1'b1;
      #1;
      check("bp_in_ready", ir, 0);
      check("bp_out_valid", ov, 1);
      held = {co, s};
      @(negedge clk);
      repeat (3) begin
         step(1'b1, ba[i], bb[i], bc[i], {1'b0, ba[i]} + {1'b0, bb[i]} + {8'd0, bc[i]}, 1'b0, acc);
         check("bp_no_accept", acc, 0);
         check("bp_hold_sum", {co, s}, held);
         check("bp_hold_valid", ov, 1);
      end
      for (int g = 0; g < 40 && i < 8; g++) begin
         step(1'b1, ba[i], bb[i], bc[i], {1'b0, ba[i]} + {1'b0, bb[i]} + {8'd0, bc[i]}, 1'b1, acc);
         if (acc) i++;
      end
      check("bp_all_accepted", i, 8);
      drain("bp");
      check("bp_out_count", n_out - out0, 8);

      // Reset mid-flight discards in-flight tokens
      for (int k = 0; k < 3; k++) step(1'b1, tv[k].a, tv[k].b, tv[k].c, {tv[k].co, tv[k].s}, 1'b0, acc);
      rst = 1'b1; iv = 1'b1; ordy = 1'b0;
      #1;
      check("midrst_in_ready", ir, 0);
      @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", ov, 0);
      check("midrst_S", s, 0);
      exp_q.delete();
      acc_q.delete();
      rst = 1'b0; iv = 1'b0;
      #1;
      check("midrst_ready_after", ir, 1);
      @(negedge clk);
      out0 = n_out;
      repeat (8) step(1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
      check("midrst_no_stale", n_out - out0, 0);
      stream(2, 2);
      drain("midrst");

      // Parameter sweeps run on their own instances
      sweep_go = 1'b1;
      for (int t = 0; t < 20000 && sdone != 3'b111; t++) @(negedge clk);
      check("sweep_done", sdone, 3'b111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int unsigned W  = (g == 0) ? 1 : (g == 1) ? 16 : 8;
      localparam int unsigned ST = (g == 0) ? 1 : (g == 1) ? 8 : 1;

      logic         srst, siv, sir, sordy, scin, sco, sov;
      logic [W-1:0] sa, sb, ss;
      logic [W:0]   q [$];

      pipelined_rca_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
         .clk(clk), .rst(srst), .A(sa), .B(sb), .cin(scin), .in_valid(siv), .in_ready(sir),
         .S(ss), .cout(sco), .out_valid(sov), .out_ready(sordy)
      );

      task automatic sstep(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic c, input logic r, output logic acc);
         siv = v; sa = x; sb = y; scin = c; sordy = r;
         #1;
         acc = siv && sir;
         if (sov && sordy) begin
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL sweep%0d_unexpected_output: got %0h with nothing in flight", g, {sco, ss});
            end else begin
               check($sformatf("sweep%0d_sum", g), 32'({sco, ss}), 32'(q.pop_front()));
            end
         end
         if (acc) q.push_back((W+1)'(x) + (W+1)'(y) + (W+1)'(c));
         @(posedge clk);
         @(negedge clk);
      endtask

      initial begin
         logic acc;
         int   done_ops;
         srst = 1'b1; siv = 1'b0; sordy = 1'b0; sa = '0; sb = '0; scin = 1'b0;
         wait (sweep_go);
         repeat (2) @(negedge clk);
         srst = 1'b0;
         // Operands at zero / all-ones with both carries: the full truth table when W=1
         for (int e = 0; e < 8; e++) begin
            logic [2:0]   ev;
            logic [W-1:0] x, y;
            ev = 3'(e);
            x = ev[2] ? '1 : '0;
            y = ev[1] ? '1 : '0;
            acc = 1'b0;
            for (int t = 0; t < 10 && !acc; t++) sstep(1'b1, x, y, ev[0], 1'b1, acc);
         end
         done_ops = 0;
         for (int t = 0; t < 6000 && done_ops < 1000; t++) begin
            sstep($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 7, acc);
            if (acc) done_ops++;
         end
         check($sformatf("sweep%0d_ops", g), done_ops, 1000);
         for (int t = 0; t < 40 && q.size() != 0; t++) sstep(1'b0, '0, '0, 1'b0, 1'b1, acc);
         check($sformatf("sweep%0d_drained", g), q.size(), 0);
         sdone[g] = 1'b1;
      end
   end

endmodule
